// File: rtl/data_mem_responder.sv
// Data-memory responder: single-ported word RAM with byte-lane writes,
// programmable wait states and an out-of-range error flag.
module data_mem_responder #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned LATENCY   = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0000_2000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        mem_rd_wr,
  input  logic [3:0]  mask,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_write_data,
  output logic [31:0] mem_read_data,
  output logic        mem_valid,
  output logic        err,
  output logic        busy
);

  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int unsigned TAG_LO = ADDR_W + 2;
  localparam logic [3:0]  LAT    = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state, state_next;
  logic [3:0]        cnt, cnt_next;
  logic              capture;

  logic              rd_q;
  logic [3:0]        mask_q;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;

  logic [31:0]       ram [DEPTH];

  logic [31:0]       sel_addr;
  logic              sel_rd;
  logic              sel_in_range;
  logic [ADDR_W-1:0] sel_idx;
  logic              in_range_q;
  logic [ADDR_W-1:0] idx_q;
  logic              unused_addr_bits;

  // Request view: live inputs while IDLE (zero-latency path), captured copy otherwise
  always_comb begin
    sel_addr     = (state == IDLE) ? mem_addr : addr_q;
    sel_rd       = (state == IDLE) ? mem_rd_wr : rd_q;
    sel_in_range = (sel_addr[31:TAG_LO] == BASE_ADDR[31:TAG_LO]);
    sel_idx      = sel_addr[TAG_LO-1:2];
    in_range_q   = (addr_q[31:TAG_LO] == BASE_ADDR[31:TAG_LO]);
    idx_q        = addr_q[TAG_LO-1:2];
  end

  assign unused_addr_bits = ^sel_addr[1:0];

  // Next-state and wait-counter logic
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (cs) begin
          capture    = 1'b1;
          cnt_next   = LAT;
          state_next = (LAT == 4'd0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_next = cnt - 4'd1;
        if (cnt == 4'd1) state_next = RESP;
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, request capture and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= 4'd0;
      rd_q          <= 1'b0;
      mask_q        <= 4'd0;
      addr_q        <= 32'd0;
      wdata_q       <= 32'd0;
      mem_valid     <= 1'b0;
      err           <= 1'b0;
      busy          <= 1'b0;
      mem_read_data <= 32'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (capture) begin
        rd_q    <= mem_rd_wr;
        mask_q  <= mask;
        addr_q  <= mem_addr;
        wdata_q <= mem_write_data;
      end
      mem_valid <= (state_next == RESP);
      err       <= (state_next == RESP) && !sel_in_range;
      busy      <= (state_next != IDLE);
      if ((state_next == RESP) && sel_rd) begin
        mem_read_data <= sel_in_range ? ram[sel_idx] : 32'd0;
      end
    end
  end

  // Byte-lane write commit at the edge that ends RESP; suppressed while reset is high
  always_ff @(posedge clk) begin
    if (!reset && (state == RESP) && !rd_q && in_range_q) begin
      for (int i = 0; i < 4; i++) begin
        if (mask_q[i]) ram[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule
